// File: rtl/cipher_link_pkg.sv
// Shared definitions for the 16-bit cipher bit-serial link (transmitter and receiver sides).
package cipher_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } tx_state_t;

  localparam int CIPHER_WORD_W    = 16;
  localparam int CIPHER_SETUP_CYC = 1;
  localparam int CIPHER_HOLD_CYC  = 2;
  localparam int CIPHER_GAP_CYC   = 2;

endpackage

// File: rtl/cipher_serial_tx.sv
// Bit-serial MSB-first transmitter with a per-bit tx_ready strobe for the chip-to-chip cipher link.
// Define CIPHER_TX_PARITY_EN to append an even-parity frame after the data frames.
module cipher_serial_tx
  import cipher_link_pkg::*;
#(
  parameter int WIDTH     = CIPHER_WORD_W,
  parameter int SETUP_CYC = CIPHER_SETUP_CYC,
  parameter int HOLD_CYC  = CIPHER_HOLD_CYC,
  parameter int GAP_CYC   = CIPHER_GAP_CYC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             tx_bit,
  output logic             tx_ready
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_SH > GAP_CYC) ? MAX_SH : GAP_CYC;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int CNT_W   = $clog2(WIDTH + 2);
`ifdef CIPHER_TX_PARITY_EN
  localparam int FRAMES  = WIDTH + 1;
`else
  localparam int FRAMES  = WIDTH;
`endif

  localparam logic [CNT_W-1:0]   LAST_FRAME = CNT_W'(FRAMES - 1);
  localparam logic [TIMER_W-1:0] SETUP_LAST = TIMER_W'(SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYC - 1);

  tx_state_t          state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tx_bit_q, tx_bit_d;
  logic               tx_ready_q, tx_ready_d;

`ifdef CIPHER_TX_PARITY_EN
  logic               parity_q, parity_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
`ifdef CIPHER_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          shreg_d   = load_data;
          bit_cnt_d = '0;
          timer_d   = '0;
`ifdef CIPHER_TX_PARITY_EN
          parity_d  = even_parity(load_data);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (timer_q == SETUP_LAST) begin
          state_d = STROBE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STROBE: begin
        if (timer_q == HOLD_LAST) begin
          state_d = GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          timer_d   = '0;
          if (bit_cnt_q == LAST_FRAME) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: begin
        state_d   = IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
        timer_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    tx_ready_d = (state_d == STROBE);
`ifdef CIPHER_TX_PARITY_EN
    if (bit_cnt_d == CNT_W'(WIDTH)) begin
      tx_bit_d = parity_d;
    end else begin
      tx_bit_d = shreg_d[WIDTH-1];
    end
`else
    tx_bit_d   = shreg_d[WIDTH-1];
`endif
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_ready_q <= 1'b0;
`ifdef CIPHER_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_bit_q   <= tx_bit_d;
      tx_ready_q <= tx_ready_d;
`ifdef CIPHER_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_bit   = tx_bit_q;
  assign tx_ready = tx_ready_q;

endmodule
